// File: rtl/mem_loader_pkg.sv
// Shared constants for the boot loader and the 24-bit word memory it feeds.
// Holds the word/address geometry and the load range check.
package mem_loader_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 24;
  localparam int DEPTH  = 256;
  localparam int BPW    = DATA_W / 8;

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // One extra bit so base+count cannot wrap past the top of the address space.
  function automatic logic load_in_range(input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] count);
    logic [ADDR_W:0] last_plus_one;
    last_plus_one = {1'b0, base} + {1'b0, count};
    return (last_plus_one <= DEPTH_EXT);
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write port of the loader.
// The master side is the loader; the slave side is the byte source plus the memory.
interface mem_loader_if;

  logic                              byte_valid;
  logic [7:0]                        byte_data;
  logic                              byte_ready;
  logic [mem_loader_pkg::DATA_W-1:0] mem_din;
  logic [mem_loader_pkg::ADDR_W-1:0] mem_addr;
  logic                              mem_we;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_din, mem_addr, mem_we
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_din, mem_addr, mem_we
  );

endinterface

// File: rtl/mem_loader_packer.sv
// Collects bytes MSB first into one memory word.
// last_byte flags that the next shift completes the word.
module mem_loader_packer
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              last_byte
);

  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [7:0]       lane_reg [BPW];
  logic [IDX_W-1:0] index_reg;

  assign last_byte = (index_reg == IDX_W'(BPW - 1));

  // Lane 0 takes the newest byte, so the first byte ends up in the top lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_reg[0] <= '0;
    end else if (shift) begin
      lane_reg[0] <= byte_in;
    end
  end

  generate
    for (genvar gi = 1; gi < BPW; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lane_reg[gi] <= '0;
        end else if (shift) begin
          lane_reg[gi] <= lane_reg[gi-1];
        end
      end
    end

    for (genvar gi = 0; gi < BPW; gi++) begin : g_word
      assign word[gi*8 +: 8] = lane_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index_reg <= '0;
    end else if (clear) begin
      index_reg <= '0;
    end else if (shift) begin
      index_reg <= last_byte ? '0 : index_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: packs an 8-bit byte stream into memory words written to
// consecutive addresses from base_addr, with range check, abort and checksum.
module mem_loader
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  mem_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] remaining_reg;
  logic              err_reg;
  logic [7:0]        checksum_reg;

  logic load, zero_load, reject, advance;
  logic transfer, last_byte;

  assign bus.byte_ready = (state_reg == COLLECT);
  assign bus.mem_we     = (state_reg == WRITE);
  assign bus.mem_addr   = addr_reg;
  assign busy           = (state_reg == COLLECT) || (state_reg == WRITE);
  assign done           = (state_reg == DONE);
  assign err            = err_reg;
  assign checksum       = checksum_reg;

  assign transfer = bus.byte_valid && (state_reg == COLLECT);

  mem_loader_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (load),
    .shift     (transfer),
    .byte_in   (bus.byte_data),
    .word      (bus.mem_din),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    zero_load  = 1'b0;
    reject     = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            zero_load  = 1'b1;
            state_next = DONE;
          end else if (!load_in_range(base_addr, word_count)) begin
            reject = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (transfer && last_byte) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        // The write itself has already happened this cycle; abort only stops the rest.
        if (abort) begin
          state_next = IDLE;
        end else if (remaining_reg == ADDR_W'(1)) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = COLLECT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      err_reg       <= 1'b0;
      checksum_reg  <= '0;
    end else begin
      if (load) begin
        addr_reg      <= base_addr;
        remaining_reg <= word_count;
        err_reg       <= 1'b0;
        checksum_reg  <= '0;
      end
      if (zero_load) begin
        err_reg <= 1'b0;
      end
      if (reject) begin
        err_reg <= 1'b1;
      end
      if (transfer) begin
        checksum_reg <= checksum_reg + bus.byte_data;
      end
      if (advance) begin
        addr_reg      <= addr_reg + 1'b1;
        remaining_reg <= remaining_reg - 1'b1;
      end
    end
  end

endmodule
